lit_frame_stats: RTL

LIT_FRAME_STATS -- requirements
Module: lit_frame_stats

---
 rtl/lit_pkg.sv | 13 +
 rtl/lit_minmax_upd.sv | 15 +
 rtl/lit_frame_stats.sv | 123 ++++++++++++
 3 files changed

// File: rtl/lit_pkg.sv
// Shared definitions for the LIT frame-statistics stage: FSM state type and
// default widths for the LDR pixel and the per-frame pixel counter.
package lit_pkg;

  localparam int LIT_IN_DEF = 8;
  localparam int CNT_W_DEF  = 22;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } lit_state_t;

endpackage : lit_pkg

// File: rtl/lit_minmax_upd.sv
// Combinational update of running min/max with one new pixel (unsigned compare).
module lit_minmax_upd #(
  parameter int W = 8
) (
  input  logic [W-1:0] pix,
  input  logic [W-1:0] cur_min,
  input  logic [W-1:0] cur_max,
  output logic [W-1:0] new_min,
  output logic [W-1:0] new_max
);

  assign new_min = (pix < cur_min) ? pix : cur_min;
  assign new_max = (pix > cur_max) ? pix : cur_max;

endmodule : lit_minmax_upd

// File: rtl/lit_frame_stats.sv
// Per-frame min/max/count statistics on the LDR pixel stream, plus a one-cycle
// registered pass-through of that stream toward LIT_in.
module lit_frame_stats
  import lit_pkg::*;
#(
  parameter int LIT_IN = LIT_IN_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LIT_IN-1:0] pix_in,
  input  logic              pix_vld,
  input  logic              pix_sof,
  input  logic              pix_eof,
  output logic [LIT_IN-1:0] pix_out,
  output logic              pix_out_vld,
  output logic [LIT_IN-1:0] stat_min,
  output logic [LIT_IN-1:0] stat_max,
  output logic [CNT_W-1:0]  stat_cnt,
  output logic              stat_vld,
  output logic              stat_err
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  lit_state_t        state, state_nxt;
  logic [LIT_IN-1:0] run_min, run_max, min_nxt, max_nxt;
  logic [CNT_W-1:0]  run_cnt, cnt_nxt, cnt_inc;
  logic [LIT_IN-1:0] upd_min, upd_max;
  logic              pub, err;
  logic [LIT_IN-1:0] pub_min, pub_max;
  logic [CNT_W-1:0]  pub_cnt;

  lit_minmax_upd #(.W(LIT_IN)) u_minmax (
    .pix     (pix_in),
    .cur_min (run_min),
    .cur_max (run_max),
    .new_min (upd_min),
    .new_max (upd_max)
  );

  // Counter sticks at all-ones instead of wrapping on oversized frames.
  assign cnt_inc = (&run_cnt) ? run_cnt : run_cnt + CNT_ONE;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    state_nxt = state;
    min_nxt   = run_min;
    max_nxt   = run_max;
    cnt_nxt   = run_cnt;
    pub       = 1'b0;
    err       = 1'b0;
    pub_min   = stat_min;
    pub_max   = stat_max;
    pub_cnt   = stat_cnt;
    if (pix_vld) begin
      if (pix_sof) begin
        // A new sof while accumulating drops the partial frame and restarts.
        err = (state == ACCUM);
        if (pix_eof) begin
          pub       = 1'b1;
          pub_min   = pix_in;
          pub_max   = pix_in;
          pub_cnt   = CNT_ONE;
          state_nxt = IDLE;
        end else begin
          min_nxt   = pix_in;
          max_nxt   = pix_in;
          cnt_nxt   = CNT_ONE;
          state_nxt = ACCUM;
        end
      end else if (state == ACCUM) begin
        min_nxt = upd_min;
        max_nxt = upd_max;
        cnt_nxt = cnt_inc;
        if (pix_eof) begin
          pub       = 1'b1;
          pub_min   = upd_min;
          pub_max   = upd_max;
          pub_cnt   = cnt_inc;
          state_nxt = IDLE;
        end
      end else if (pix_eof) begin
        err = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      run_min     <= '0;
      run_max     <= '0;
      run_cnt     <= '0;
      pix_out     <= '0;
      pix_out_vld <= 1'b0;
      stat_min    <= '0;
      stat_max    <= '0;
      stat_cnt    <= '0;
      stat_vld    <= 1'b0;
      stat_err    <= 1'b0;
    end else begin
      run_min     <= min_nxt;
      run_max     <= max_nxt;
      run_cnt     <= cnt_nxt;
      pix_out_vld <= pix_vld;
      if (pix_vld) pix_out <= pix_in;
      stat_min    <= pub_min;
      stat_max    <= pub_max;
      stat_cnt    <= pub_cnt;
      stat_vld    <= pub;
      stat_err    <= err;
    end
  end

endmodule : lit_frame_stats
